sobel_grad_3x3: RTL and testbench

//  Canny stage 2: consumes the 3x3 window (a1..a9, row-major, a9 = newest pixel) from the
//  3x3 line-buffer operator stage and produces Sobel gradient magnitude plus quantised

---
 rtl/sobel_grad_3x3_pkg.sv | 35 +++
 rtl/sobel_grad_3x3_dir.sv | 33 +++
 rtl/sobel_grad_3x3.sv | 143 ++++++++++++++
 tb/tb_sobel_grad_3x3.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sobel_grad_3x3_pkg.sv
// Shared constants and helpers for the Sobel gradient stage and the downstream NMS stage.
package sobel_grad_3x3_pkg;

  localparam int GRAD_W   = 11;
  localparam int MAG_W    = GRAD_W - 1;
  localparam int PROD_W   = 20;
  localparam int TAN22_Q8 = 106;
  localparam int TAN67_Q8 = 618;

  typedef enum logic [1:0] {
    DIR_0   = 2'd0,
    DIR_45  = 2'd1,
    DIR_90  = 2'd2,
    DIR_135 = 2'd3
  } grad_dir_e;

  // Constant multiply built only from shifts and adds of the set bits of k.
  function automatic logic [PROD_W-1:0] mul_const(input logic [MAG_W-1:0] v, input int k);
    logic [PROD_W-1:0] x;
    logic [PROD_W-1:0] acc;
    x   = PROD_W'(v);
    acc = '0;
    for (int i = 0; i < PROD_W; i++) begin
      if (k[i]) acc = acc + (x << i);
    end
    return acc;
  endfunction

  function automatic logic [MAG_W-1:0] abs_grad(input logic [GRAD_W-1:0] v);
    logic [GRAD_W-1:0] n;
    n = ~v + GRAD_W'(1);
    return v[GRAD_W-1] ? n[MAG_W-1:0] : v[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_grad_3x3_dir.sv
// Gradient direction quantiser: compares |Gy| against |Gx|*tan(22.5/67.5) in Q8 and registers the sector.
module grad_dir_quant
  import sobel_grad_3x3_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld,
  input  logic              border,
  input  logic              sgn,
  input  logic [PROD_W-1:0] gx_t22,
  input  logic [PROD_W-1:0] gx_t67,
  input  logic [PROD_W-1:0] gy_q8,
  output logic [1:0]        grad_dir
);

  grad_dir_e dir_c;

  // A zero gradient would otherwise fall through both compares into a diagonal sector.
  always_comb begin
    dir_c = DIR_0;
    if (border || (gx_t22 == '0 && gy_q8 == '0)) dir_c = DIR_0;
    else if (gy_q8 < gx_t22)                      dir_c = DIR_0;
    else if (gy_q8 > gx_t67)                      dir_c = DIR_90;
    else if (sgn)                                 dir_c = DIR_135;
    else                                          dir_c = DIR_45;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   grad_dir <= 2'd0;
    else if (vld) grad_dir <= dir_c;
  end

endmodule

// File: rtl/sobel_grad_3x3.sv
// Canny stage 2: 3-cycle pipelined Sobel gradient magnitude and quantised direction,
// with frame position tracking so top/left border windows are zeroed.
module sobel_grad_3x3
  import sobel_grad_3x3_pkg::*;
#(
  parameter int IMG_W = 1024,
  parameter int IMG_H = 768,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          win_vld,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] a2,
  input  logic [DW-1:0] a3,
  input  logic [DW-1:0] a4,
  input  logic [DW-1:0] a5,
  input  logic [DW-1:0] a6,
  input  logic [DW-1:0] a7,
  input  logic [DW-1:0] a8,
  input  logic [DW-1:0] a9,
  output logic [DW-1:0] grad_mag,
  output logic [1:0]    grad_dir,
  output logic          dout_vld,
  output logic          dout_eof
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last_col, last_row, border_c;

  logic [GRAD_W-1:0] gx_pos, gx_neg, gy_pos, gy_neg, gx_c, gy_c;

  logic              s1_vld, s1_border, s1_eof;
  logic [GRAD_W-1:0] s1_gx, s1_gy;

  logic              s2_vld, s2_border, s2_eof, s2_sgn;
  logic [MAG_W-1:0]  s2_abs_gx, s2_abs_gy;
  logic [PROD_W-1:0] s2_gx_t22, s2_gx_t67, s2_gy_q8;

  logic [GRAD_W-1:0] mag_sum;

  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));
  assign border_c = (col < CW'(2)) || (row < RW'(2));

  // Sums are non-negative and fit in GRAD_W; the modular difference is the signed gradient.
  assign gx_pos = GRAD_W'(a3) + (GRAD_W'(a6) << 1) + GRAD_W'(a9);
  assign gx_neg = GRAD_W'(a1) + (GRAD_W'(a4) << 1) + GRAD_W'(a7);
  assign gy_pos = GRAD_W'(a7) + (GRAD_W'(a8) << 1) + GRAD_W'(a9);
  assign gy_neg = GRAD_W'(a1) + (GRAD_W'(a2) << 1) + GRAD_W'(a3);
  assign gx_c   = gx_pos - gx_neg;
  assign gy_c   = gy_pos - gy_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (win_vld) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_border <= 1'b0;
      s1_eof    <= 1'b0;
      s1_gx     <= '0;
      s1_gy     <= '0;
    end else begin
      s1_vld    <= win_vld;
      s1_border <= border_c;
      s1_eof    <= win_vld && last_col && last_row;
      s1_gx     <= gx_c;
      s1_gy     <= gy_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld    <= 1'b0;
      s2_border <= 1'b0;
      s2_eof    <= 1'b0;
      s2_sgn    <= 1'b0;
      s2_abs_gx <= '0;
      s2_abs_gy <= '0;
      s2_gx_t22 <= '0;
      s2_gx_t67 <= '0;
      s2_gy_q8  <= '0;
    end else begin
      s2_vld    <= s1_vld;
      s2_border <= s1_border;
      s2_eof    <= s1_eof;
      s2_sgn    <= s1_gx[GRAD_W-1] ^ s1_gy[GRAD_W-1];
      s2_abs_gx <= abs_grad(s1_gx);
      s2_abs_gy <= abs_grad(s1_gy);
      s2_gx_t22 <= mul_const(abs_grad(s1_gx), TAN22_Q8);
      s2_gx_t67 <= mul_const(abs_grad(s1_gx), TAN67_Q8);
      s2_gy_q8  <= PROD_W'(abs_grad(s1_gy)) << 8;
    end
  end

  assign mag_sum = GRAD_W'(s2_abs_gx) + GRAD_W'(s2_abs_gy);

  // Magnitude and direction hold through bubbles; the eof tag is a single-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grad_mag <= '0;
      dout_vld <= 1'b0;
      dout_eof <= 1'b0;
    end else begin
      dout_vld <= s2_vld;
      dout_eof <= s2_vld && s2_eof;
      if (s2_vld) begin
        if (s2_border)                          grad_mag <= '0;
        else if (mag_sum > GRAD_W'((1 << DW) - 1)) grad_mag <= '1;
        else                                    grad_mag <= mag_sum[DW-1:0];
      end
    end
  end

  grad_dir_quant u_dir (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld      (s2_vld),
    .border   (s2_border),
    .sgn      (s2_sgn),
    .gx_t22   (s2_gx_t22),
    .gx_t67   (s2_gx_t67),
    .gy_q8    (s2_gy_q8),
    .grad_dir (grad_dir)
  );

endmodule

// File: tb/tb_sobel_grad_3x3.sv
// Directed bench for sobel_grad_3x3 on an 8x4 frame with hand-computed window results.
module tb_sobel_grad_3x3;

  localparam int W = 8;
  localparam int H = 4;

  localparam int P_FLAT = 0;
  localparam int P_VERT = 1;
  localparam int P_HORZ = 2;
  localparam int P_DIAG = 3;
  localparam int P_MIRR = 4;
  localparam int P_VNEG = 5;
  localparam int P_D2   = 6;

  logic       clk;
  logic       rst_n;
  logic       win_vld;
  logic [7:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
  logic [7:0] grad_mag;
  logic [1:0] grad_dir;
  logic       dout_vld;
  logic       dout_eof;

  logic [7:0] pat_win [7][9];
  int         pat_mag [7];
  int         pat_dir [7];

  int total;
  int bad;
  int col, row;
  int last_mag, last_dir;
  logic ev [3];
  int   em [3];
  int   ed [3];
  logic ee [3];

  sobel_grad_3x3 #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .win_vld  (win_vld),
    .a1       (a1),
    .a2       (a2),
    .a3       (a3),
    .a4       (a4),
    .a5       (a5),
    .a6       (a6),
    .a7       (a7),
    .a8       (a8),
    .a9       (a9),
    .grad_mag (grad_mag),
    .grad_dir (grad_dir),
    .dout_vld (dout_vld),
    .dout_eof (dout_eof)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      ev[i] = 1'b0;
      em[i] = 0;
      ed[i] = 0;
      ee[i] = 1'b0;
    end
    col      = 0;
    row      = 0;
    last_mag = 0;
    last_dir = 0;
  endtask

  // Outputs visible after an edge belong to the window sampled two edges earlier.
  task automatic check_output();
    chk("dout_vld", int'(dout_vld), int'(ev[2]));
    if (ev[2]) begin
      chk("grad_mag", int'(grad_mag), em[2]);
      chk("grad_dir", int'(grad_dir), ed[2]);
      chk("dout_eof", int'(dout_eof), int'(ee[2]));
      last_mag = em[2];
      last_dir = ed[2];
    end else begin
      chk("hold_mag", int'(grad_mag), last_mag);
      chk("hold_dir", int'(grad_dir), last_dir);
      chk("gap_eof", int'(dout_eof), 0);
    end
  endtask

  task automatic apply_stimulus(input logic vld, input int pat);
    logic border;
    win_vld = vld;
    a1 = pat_win[pat][0]; a2 = pat_win[pat][1]; a3 = pat_win[pat][2];
    a4 = pat_win[pat][3]; a5 = pat_win[pat][4]; a6 = pat_win[pat][5];
    a7 = pat_win[pat][6]; a8 = pat_win[pat][7]; a9 = pat_win[pat][8];
    @(posedge clk);
    #1;
    for (int i = 2; i > 0; i--) begin
      ev[i] = ev[i-1]; em[i] = em[i-1]; ed[i] = ed[i-1]; ee[i] = ee[i-1];
    end
    ev[0] = vld;
    em[0] = 0;
    ed[0] = 0;
    ee[0] = 1'b0;
    if (vld) begin
      border = (col < 2) || (row < 2);
      em[0]  = border ? 0 : pat_mag[pat];
      ed[0]  = border ? 0 : pat_dir[pat];
      ee[0]  = (col == W - 1) && (row == H - 1);
      if (col == W - 1) begin
        col = 0;
        row = (row == H - 1) ? 0 : row + 1;
      end else begin
        col = col + 1;
      end
    end
    check_output();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    pat_win[P_FLAT] = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
    pat_win[P_VERT] = '{0, 25, 50, 0, 25, 50, 0, 25, 50};
    pat_win[P_HORZ] = '{0, 0, 0, 25, 25, 25, 50, 50, 50};
    pat_win[P_DIAG] = '{0, 0, 25, 0, 25, 50, 25, 50, 50};
    pat_win[P_MIRR] = '{25, 0, 0, 50, 25, 0, 50, 50, 25};
    pat_win[P_VNEG] = '{50, 25, 0, 50, 25, 0, 50, 25, 0};
    pat_win[P_D2]   = '{0, 0, 0, 0, 0, 25, 0, 25, 50};
    pat_mag = '{0, 200, 200, 255, 255, 200, 200};
    pat_dir = '{0, 0, 2, 1, 3, 0, 1};
    clear_model();

    rst_n   = 1'b0;
    win_vld = 1'b0;
    {a1, a2, a3, a4, a5, a6, a7, a8, a9} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", int'(dout_vld), 0);
    chk("rst_mag", int'(grad_mag), 0);
    chk("rst_dir", int'(grad_dir), 0);
    chk("rst_eof", int'(dout_eof), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame A: vertical edges with special interior windows and a 1,0,0,1,1 bubble run.
    for (int idx = 0; idx < W * H; idx++) begin
      if (idx == 19) begin
        apply_stimulus(1'b0, P_DIAG);
        apply_stimulus(1'b0, P_DIAG);
      end
      case (idx)
        18:      apply_stimulus(1'b1, P_HORZ);
        19:      apply_stimulus(1'b1, P_FLAT);
        20:      apply_stimulus(1'b1, P_DIAG);
        21:      apply_stimulus(1'b1, P_MIRR);
        22:      apply_stimulus(1'b1, P_VNEG);
        23:      apply_stimulus(1'b1, P_D2);
        default: apply_stimulus(1'b1, P_VERT);
      endcase
    end

    // Frame B back-to-back: all vertical edges, border zeroing and eof on the last pixel.
    for (int idx = 0; idx < W * H; idx++) apply_stimulus(1'b1, P_VERT);
    repeat (3) apply_stimulus(1'b0, P_FLAT);

    // Asynchronous reset mid-line with pixels in flight.
    for (int idx = 0; idx < 10; idx++) apply_stimulus(1'b1, P_VERT);
    @(negedge clk);
    rst_n   = 1'b0;
    win_vld = 1'b0;
    #1;
    chk("async_rst_vld", int'(dout_vld), 0);
    chk("async_rst_mag", int'(grad_mag), 0);
    chk("async_rst_eof", int'(dout_eof), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    for (int idx = 0; idx < 20; idx++) apply_stimulus(1'b1, P_VERT);
    repeat (3) apply_stimulus(1'b0, P_FLAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
